ntt_result_unpacker: RTL
========================

# ntt_result_unpacker

Downstream collector for the NTT1024 core. After `done`, it captures the core's `dout0` word stream. The stream is interleaved: even words belong to the lower half of the polynomial, odd words to the upper half. The block de-interleaves the words into natural coefficient order, applies a final conditional subtraction of `q`, and stores the results in an internal buffer. The host reads the finished polynomial through a simple 1-cycle-latency read port.

## Interface

Parameters:
- `DATA_W`, 32: coefficient word width, matches `dout0`.
- `ADDR_W`, 10: buffer address width; maximum ring size is 2^ADDR_W.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `clear`, input, 1: synchronous return to IDLE.
- `ring_size`, input, 12: number of coefficients; a power of two, 2..2^ADDR_W. Latched on IDLE→CAPTURE.
- `q`, input, DATA_W: modulus. Latched with `ring_size`.
- `core_done`, input, 1: `done` from NTT1024.
- `core_dout_valid`, input, 1: qualifies `core_dout`.
- `core_dout`, input, DATA_W: `dout0` from NTT1024.
- `rd_en`, input, 1: host read request.
- `rd_addr`, input, ADDR_W: coefficient index to read.
- `rd_data`, output, DATA_W: read data.
- `rd_valid`, output, 1: `rd_data` is valid this cycle.
- `ready`, output, 1: buffer holds a complete polynomial.
- `busy`, output, 1: in CAPTURE.
- `ovf`, output, 1: sticky; a valid word arrived while the block was in FULL.

## Operation

State machine:
- IDLE → CAPTURE on a `core_done` rising edge. On this transition, latch `ring_size`, `q`, and `half = ring_size>>1`, and clear the word counter `m`.
- CAPTURE: each `core_dout_valid` consumes one word.
  - Destination address is `m>>1` when `m[0]==0`, else `(m>>1)+half`.
  - Increment `m`.
  - On the word with `m == ring_size-1`, go to FULL.
- FULL: `ready`=1. Reads are served. Valid words are dropped and set `ovf`.
- `clear` in any state → IDLE. It zeroes `m`, `ready`, `busy`, and `ovf`. Buffer contents are kept but are not readable.

Rules:
- `clear` has priority over `core_dout_valid` and `core_done` in the same cycle.
- `core_done` is ignored in CAPTURE and FULL.
- Valid words in IDLE are ignored and do not set `ovf`.
- Arithmetic: stored value = `core_dout - q` if `core_dout >= q`, else `core_dout`. The comparison is unsigned at full DATA_W. Only one subtraction is applied.
- `rd_en` while `ready==0` is ignored: `rd_valid` stays 0 and `rd_data` holds its last value.
- `rd_addr >= latched ring_size` returns buffer content. This is undefined data, not an error.

## Timing

- Reset values: `rd_data`=0, `rd_valid`=0, `ready`=0, `busy`=0, `ovf`=0, state IDLE.
- Reset mid-capture aborts the capture with no partial `ready`.
- Capture pipeline:
  - Edge k: valid word registered together with its address; the reduction is computed.
  - Edge k+1: buffer written.
- `ready` rises at the same edge as the final buffer write (edge k+1 for the last word). `busy` falls at that edge.
- Back-to-back valid words are accepted every cycle. Gaps in `core_dout_valid` are allowed.
- Read: `rd_en` sampled at edge t; `rd_data`/`rd_valid` are valid after edge t for one cycle. Reads can be issued every cycle.
- A write and a read to the same address cannot occur in the same cycle, because reads happen only in FULL.

## Configuration

- `UNPACK_REDUCE_EN` defined: the conditional subtraction of `q` is compiled in, as described above.
- `UNPACK_REDUCE_EN` undefined:
  - Words are stored unchanged and `q` is unused.
  - The pipeline latency stays the same, so the timing is identical.

## Test plan

- Reset, then `core_done` pulse with `ring_size`=256 and `q`=3329. Stream `m`=0..255 with `core_dout`=`m`. Expected: `ready` is high after the last write; reading addr 0, 1, 128, 129 returns 0, 2, 1, 3.
- Reduction (`UNPACK_REDUCE_EN` defined), `q`=3329. Inputs 3328, 3329, 6657 must read back as 3328, 0, 3328. With the macro undefined, the same inputs read back as 3328, 3329, 6657.
- Gapped stream: `ring_size`=8 with `core_dout_valid` toggling every other cycle. Expected: `busy` stays 1 until the last write and `ready` rises exactly 1 cycle after the 8th valid word.
- Overflow and `clear`:
  - After FULL, a 9th valid word sets `ovf` and leaves the buffer unchanged.
  - `clear` drops `ready` and `ovf`; `rd_en` then gives `rd_valid`=0.
  - `clear` asserted together with a valid word: the word is not captured.
- Asynchronous `reset` asserted after 100 of 256 words. Expected: all outputs return to 0 immediately. A new `core_done` and a full 256-word stream then give a correct `ready` and correct data.
- Read latency: `rd_en` every cycle for addr 0..7 with `ring_size`=8. Expected: `rd_valid` is high for 8 consecutive cycles, lagging `rd_en` by 1, with data in order.

Source files
------------

// File: rtl/ntt_result_unpacker.sv
// ntt_result_unpacker: de-interleaves the NTT1024 dout0 stream into natural coefficient order and buffers it for the host.
// Latency: a word is registered and reduced at its own edge and written to the buffer one edge later; reads return 1 cycle after rd_en.
// Backpressure: none. One word per cycle is accepted in CAPTURE. Words that arrive in FULL are dropped and set the sticky ovf flag.
// Build option: define UNPACK_REDUCE_EN to compile in the single conditional subtraction of q. Without it, words are stored unchanged.
module ntt_result_unpacker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10   // at most 11: addresses are sliced out of the 12-bit word counter
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [11:0]       ring_size,
  input  logic [DATA_W-1:0] q,
  input  logic              core_done,
  input  logic              core_dout_valid,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Parameters of the capture, latched when it starts.
  logic [11:0]       ring_q;
  logic [ADDR_W-1:0] half_q;
  logic [11:0]       m_q;
  logic [11:0]       ring_last;

  logic done_d;
  logic done_rise;
  logic start_cap;
  logic accept;

  // Word pipeline stage: holds the registered word between its capture edge and its buffer write.
  logic              wr_vld_q;
  logic              wr_last_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_dat_q;
  logic [DATA_W-1:0] red_dat;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign done_rise = core_done && !done_d;
  assign start_cap = (state_q == ST_IDLE) && done_rise && !clear;
  assign ring_last = ring_q - 12'd1;

`ifdef UNPACK_REDUCE_EN
  logic [DATA_W-1:0] q_q;

  // Latch the modulus with the ring size at the start of a capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (start_cap) begin
      q_q <= q;
    end
  end

  // The core output is at most one q above the range, so a single subtraction is enough.
  assign red_dat = (core_dout >= q_q) ? (core_dout - q_q) : core_dout;
`else
  logic unused_q;
  assign unused_q = ^q;
  assign red_dat  = core_dout;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and word acceptance. Clear wins over everything else. FULL is entered when the last word is written.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (done_rise) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Once the final word sits in the pipeline, the polynomial is complete. Any further word is not taken.
          accept = core_dout_valid && !(wr_vld_q && wr_last_q);
          if (wr_vld_q && wr_last_q) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          state_d = ST_FULL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Capture bookkeeping: latch parameters, count words, register each word with its de-interleaved address, and set overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_d    <= 1'b0;
      ring_q    <= '0;
      half_q    <= '0;
      m_q       <= '0;
      wr_vld_q  <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      ovf       <= 1'b0;
    end else begin
      done_d    <= core_done;
      wr_vld_q  <= 1'b0;
      wr_last_q <= 1'b0;
      if (clear) begin
        m_q <= '0;
        ovf <= 1'b0;
      end else begin
        if (start_cap) begin
          ring_q <= ring_size;
          half_q <= ring_size[ADDR_W:1];
          m_q    <= '0;
        end
        if (accept) begin
          // Even words go to the lower half and odd words to the upper half.
          wr_vld_q  <= 1'b1;
          wr_last_q <= (m_q == ring_last);
          wr_addr_q <= m_q[ADDR_W:1] + (m_q[0] ? half_q : '0);
          wr_dat_q  <= red_dat;
          m_q       <= m_q + 12'd1;
        end
        if ((state_q == ST_FULL) && core_dout_valid) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Buffer write. The buffer has no reset: its contents only become visible again through a completed capture.
  always_ff @(posedge clk) begin
    if (wr_vld_q) begin
      mem[wr_addr_q] <= wr_dat_q;
    end
  end

  // Host read port. Reads are served only while a complete polynomial is held. Otherwise rd_data keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && (state_q == ST_FULL);
      if (rd_en && (state_q == ST_FULL)) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  assign ready = (state_q == ST_FULL);
  assign busy  = (state_q == ST_CAPTURE);

endmodule
